// File: rtl/da_lut_loader.sv
`timescale 1ns/1ps
// Collects the FIR tap coefficients, then builds and streams the distributed-arithmetic
// partial-sum table into the filter's CIN/CADDR/CLOAD load port, one entry per handshake.
module da_lut_loader #(
   parameter int NTAPS = 64,
   parameter int GSIZE = 8,
   parameter int CW    = 16,
   parameter int LW    = 20,
   parameter int AW    = 11
) (
   input  logic          clk_fast,
   input  logic          resetn,
   input  logic          start,
   input  logic [CW-1:0] coef_in,
   input  logic          coef_valid,
   output logic          coef_ready,
   output logic [LW-1:0] CIN,
   output logic [AW-1:0] CADDR,
   output logic          CLOAD,
   output logic          cin_valid,
   input  logic          cin_ready,
   output logic          busy,
   output logic          done
);
   localparam int CNTW = $clog2(NTAPS);
   localparam int BW   = $clog2(GSIZE);

   typedef enum logic [2:0] {IDLE, COEF, ACC, EMIT, FIN} state_t;

   state_t          state_reg, state_next;
   logic [CNTW-1:0] count_reg, count_next;
   logic [BW-1:0]   bit_reg, bit_next;
   logic [AW-1:0]   addr_reg, addr_next;
   logic [LW-1:0]   acc_reg, acc_next;
   logic [LW-1:0]   cin_reg, cin_next;
   logic [AW-1:0]   caddr_reg, caddr_next;
   logic            cload_reg, cload_next;
   logic            cin_valid_reg, cin_valid_next;
   logic            done_reg, done_next;

   logic [CW-1:0]    coef_mem [NTAPS];
   logic [CW-1:0]    coef_sel;
   logic [GSIZE-1:0] m_bits;
   logic [LW-1:0]    acc_sum;
   logic             accept;

   assign accept = (state_reg == COEF) && coef_valid;

   always_ff @(posedge clk_fast) begin
      if (accept) coef_mem[count_reg] <= coef_in;
   end

   // Entry {k, m}: tap 8k+b contributes when bit b of m is set, one bit per ACC cycle.
   assign m_bits   = addr_reg[GSIZE-1:0];
   assign coef_sel = coef_mem[{addr_reg[AW-1:GSIZE], bit_reg}];
   assign acc_sum  = acc_reg + (m_bits[bit_reg] ? {{(LW-CW){coef_sel[CW-1]}}, coef_sel} : '0);

   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      bit_next       = bit_reg;
      addr_next      = addr_reg;
      acc_next       = acc_reg;
      cin_next       = cin_reg;
      caddr_next     = caddr_reg;
      cload_next     = cload_reg;
      cin_valid_next = cin_valid_reg;
      done_next      = 1'b0;
      coef_ready     = 1'b0;
      busy           = 1'b1;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = COEF;
               count_next = '0;
            end
         end
         COEF: begin
            coef_ready = 1'b1;
            if (coef_valid) begin
               count_next = count_reg + 1'b1;
               if (count_reg == CNTW'(NTAPS - 1)) begin
                  state_next = ACC;
                  addr_next  = '0;
                  acc_next   = '0;
                  bit_next   = '0;
                  cload_next = 1'b1;
               end
            end
         end
         ACC: begin
            acc_next = acc_sum;
            bit_next = bit_reg + 1'b1;
            if (bit_reg == BW'(GSIZE - 1)) begin
               state_next     = EMIT;
               cin_next       = acc_sum;
               caddr_next     = addr_reg;
               cin_valid_next = 1'b1;
            end
         end
         EMIT: begin
            if (cin_ready) begin
               cin_valid_next = 1'b0;
               if (addr_reg == {AW{1'b1}}) begin
                  state_next = FIN;
                  cload_next = 1'b0;
               end else begin
                  state_next = ACC;
                  addr_next  = addr_reg + 1'b1;
                  acc_next   = '0;
                  bit_next   = '0;
               end
            end
         end
         FIN: begin
            done_next  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_fast or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         bit_reg       <= '0;
         addr_reg      <= '0;
         acc_reg       <= '0;
         cin_reg       <= '0;
         caddr_reg     <= '0;
         cload_reg     <= 1'b0;
         cin_valid_reg <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         bit_reg       <= bit_next;
         addr_reg      <= addr_next;
         acc_reg       <= acc_next;
         cin_reg       <= cin_next;
         caddr_reg     <= caddr_next;
         cload_reg     <= cload_next;
         cin_valid_reg <= cin_valid_next;
         done_reg      <= done_next;
      end
   end

   assign CIN       = cin_reg;
   assign CADDR     = caddr_reg;
   assign CLOAD     = cload_reg;
   assign cin_valid = cin_valid_reg;
   assign done      = done_reg;

endmodule
